// File: rtl/manchester_pkg.sv
// Shared types, convention constants and the symbol encoder for the Manchester codec.
package manchester_pkg;

    typedef enum logic [1:0] {TxIdle, TxSend, TxGap} tx_state_t;
    typedef enum logic [1:0] {RxUnarmed, RxArmed, RxData, RxDone} rx_state_t;

    localparam int unsigned CONV_IEEE   = 0;
    localparam int unsigned CONV_THOMAS = 1;

    // Returns {first_half, second_half} of one data symbol.
    function automatic logic [1:0] manch_pair(input logic b, input int unsigned conv);
        logic hi_second;
        hi_second = (conv == CONV_THOMAS) ? ~b : b;
        return hi_second ? 2'b01 : 2'b10;
    endfunction

endpackage

// File: rtl/manchester_codec_p_if.sv
// Word-level transmit handshake and receive result bundle of the Manchester codec.
interface manchester_codec_p_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_err;
    logic              rx_busy;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, rx_data, rx_valid, rx_err, rx_busy
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, rx_data, rx_valid, rx_err, rx_busy
    );
endinterface

// File: rtl/manchester_sync2.sv
// Two-flop synchroniser for the asynchronous receive line; resets to 0.
module manchester_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/manchester_codec_p.sv
// Parametrised Manchester transmitter/receiver with framing and code-violation detection.
// Define MANCH_PARITY_EN to append and check an even-parity symbol after the data bits.
module manchester_codec_p
    import manchester_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned OVS        = 16,
    parameter int unsigned CONVENTION = CONV_IEEE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    manchester_codec_p_if.slave  bus,
    output logic                 tx_out,
    output logic                 tx_active,
    input  logic                 rx_in
);

`ifdef MANCH_PARITY_EN
    localparam int unsigned PAR_SYMS = 1;
`else
    localparam int unsigned PAR_SYMS = 0;
`endif

    localparam int unsigned HALF  = OVS / 2;
    localparam int unsigned CNT_W = $clog2(OVS);
    localparam int unsigned NRX   = DATA_W + PAR_SYMS;
    localparam int unsigned SYM_W = $clog2(NRX + 2);
    localparam int unsigned BIT_W = $clog2(NRX + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVS - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] PH_T0    = CNT_W'(HALF + 1);
    localparam logic [CNT_W-1:0] PH_Q1    = CNT_W'(OVS / 4);
    localparam logic [CNT_W-1:0] PH_Q3    = CNT_W'(3 * OVS / 4);
    localparam logic [SYM_W-1:0] SYM_DATA = SYM_W'(DATA_W);
    localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(NRX);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NRX - 1);

    // Symbol 0 is the start symbol, 1..DATA_W carry data MSB first, then parity.
    function automatic logic [1:0] sym_pair(input logic [SYM_W-1:0] s,
                                            input logic [DATA_W-1:0] w);
        logic [DATA_W-1:0] sh;
        sh = w << (s - 1'b1);
        if (s == '0) return 2'b01;
        if (s <= SYM_DATA) return manch_pair(sh[DATA_W-1], CONVENTION);
        return manch_pair(^w, CONVENTION);
    endfunction

    tx_state_t         tx_st;
    logic [CNT_W-1:0]  tx_cnt;
    logic [SYM_W-1:0]  tx_sym;
    logic [DATA_W-1:0] tx_word;
    logic              tx_out_q, tx_ready_q, tx_active_q;
    logic [1:0]        cur_pair, next_pair;

    assign cur_pair  = sym_pair(tx_sym, tx_word);
    assign next_pair = sym_pair(tx_sym + 1'b1, tx_word);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_st       <= TxIdle;
            tx_cnt      <= '0;
            tx_sym      <= '0;
            tx_word     <= '0;
            tx_out_q    <= 1'b0;
            tx_ready_q  <= 1'b1;
            tx_active_q <= 1'b0;
        end else begin
            case (tx_st)
                TxIdle: begin
                    if (bus.tx_valid && tx_ready_q) begin
                        tx_word     <= bus.tx_data;
                        tx_st       <= TxSend;
                        tx_cnt      <= '0;
                        tx_sym      <= '0;
                        tx_out_q    <= 1'b0;
                        tx_ready_q  <= 1'b0;
                        tx_active_q <= 1'b1;
                    end
                end
                TxSend: begin
                    if (tx_cnt == CNT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_sym == SYM_LAST) begin
                            tx_st    <= TxGap;
                            tx_out_q <= 1'b0;
                        end else begin
                            tx_sym   <= tx_sym + 1'b1;
                            tx_out_q <= next_pair[1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                        if (tx_cnt == CNT_MID) tx_out_q <= cur_pair[0];
                    end
                end
                TxGap: begin
                    if (tx_cnt == CNT_LAST) begin
                        tx_st       <= TxIdle;
                        tx_cnt      <= '0;
                        tx_ready_q  <= 1'b1;
                        tx_active_q <= 1'b0;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: tx_st <= TxIdle;
            endcase
        end
    end

    assign tx_out       = tx_out_q;
    assign tx_active    = tx_active_q;
    assign bus.tx_ready = tx_ready_q;

    logic rx_s;

    manchester_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx_in),
        .q     (rx_s)
    );

    rx_state_t         rx_st;
    logic [CNT_W-1:0]  low_cnt, rx_ph;
    logic [BIT_W-1:0]  rx_bit;
    logic [NRX-1:0]    rx_sh, rx_sh_nx;
    logic              rx_lead, rx_h1, rx_ferr, ferr_nx, dec, par_bad;
    logic [DATA_W-1:0] rx_data_q;
    logic              rx_valid_q, rx_err_q, rx_busy_q;

    always_comb begin
        dec      = (CONVENTION == CONV_IEEE) ? rx_s : rx_h1;
        rx_sh_nx = (rx_sh << 1) | NRX'(dec);
        ferr_nx  = rx_ferr | (rx_s == rx_h1);
        par_bad  = 1'b0;
`ifdef MANCH_PARITY_EN
        par_bad  = ^rx_sh_nx;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_st      <= RxUnarmed;
            low_cnt    <= '0;
            rx_ph      <= '0;
            rx_bit     <= '0;
            rx_sh      <= '0;
            rx_lead    <= 1'b0;
            rx_h1      <= 1'b0;
            rx_ferr    <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
            rx_busy_q  <= 1'b0;
        end else begin
            case (rx_st)
                RxUnarmed: begin
                    if (rx_s) begin
                        low_cnt <= '0;
                    end else if (low_cnt == CNT_LAST) begin
                        low_cnt <= '0;
                        rx_st   <= RxArmed;
                    end else begin
                        low_cnt <= low_cnt + 1'b1;
                    end
                end
                // Only low samples keep us here, so any high sample is the mid-start edge.
                RxArmed: begin
                    if (rx_s) begin
                        rx_st     <= RxData;
                        rx_busy_q <= 1'b1;
                        rx_ph     <= PH_T0;
                        rx_lead   <= 1'b1;
                        rx_bit    <= '0;
                        rx_ferr   <= 1'b0;
                        rx_sh     <= '0;
                    end
                end
                RxData: begin
                    if (rx_ph == CNT_LAST) begin
                        rx_ph   <= '0;
                        rx_lead <= 1'b0;
                    end else begin
                        rx_ph <= rx_ph + 1'b1;
                    end
                    if (!rx_lead && rx_ph == PH_Q1) rx_h1 <= rx_s;
                    if (!rx_lead && rx_ph == PH_Q3) begin
                        rx_sh   <= rx_sh_nx;
                        rx_ferr <= ferr_nx;
                        if (rx_bit == BIT_LAST) begin
                            rx_st      <= RxDone;
                            rx_busy_q  <= 1'b0;
                            rx_valid_q <= 1'b1;
                            rx_data_q  <= rx_sh_nx[NRX-1 -: DATA_W];
                            rx_err_q   <= ferr_nx | par_bad;
                        end else begin
                            rx_bit <= rx_bit + 1'b1;
                        end
                    end
                end
                RxDone: begin
                    rx_valid_q <= 1'b0;
                    low_cnt    <= '0;
                    rx_st      <= RxUnarmed;
                end
                default: rx_st <= RxUnarmed;
            endcase
        end
    end

    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.rx_err   = rx_err_q;
    assign bus.rx_busy  = rx_busy_q;

endmodule

// File: doc/manchester_codec_p.md
Name: manchester_codec_p

Overview:
Parametrised Manchester transmitter/receiver core, the next generation of the TinyTapeout Manchester design.
- Generalises word width, oversampling ratio and bit-encoding convention.
- Adds framing, code-violation detection and a valid/ready transmit handshake.
- Instantiated inside the tt_um top wrapper: tx_out drives a uo_out pin, rx_in comes from a ui_in pin.

Parameters:
DATA_W, 8, payload bits per frame (1..16)
OVS, 16, clocks per Manchester bit; multiple of 4, ≥4
CONVENTION, 0, 0 = IEEE 802.3 (1 = low→high), 1 = G.E. Thomas (1 = high→low)

Ports:
clk  in  1  single system clock
rst_n  in  1  asynchronous active-low reset
tx_data  in  DATA_W  word to transmit, MSB first
tx_valid  in  1  tx_data valid
tx_ready  out  1  transmitter can accept a word
tx_out  out  1  Manchester line output; idle low
tx_active  out  1  frame or gap in progress
rx_in  in  1  asynchronous Manchester line input
rx_data  out  DATA_W  last decoded word; held until next frame completes
rx_valid  out  1  one-cycle pulse, rx_data/rx_err valid
rx_err  out  1  code violation (or parity error) in the frame just completed
rx_busy  out  1  receiver is inside a frame

Behaviour:
- One clock domain, clk.
- rst_n asynchronous assert, synchronous release; clears all state.
- Reset values: tx_ready=1, tx_out=0, tx_active=0, rx_data=0, rx_valid=0, rx_err=0, rx_busy=0.
- Reset mid-frame aborts both directions with no rx_valid; tx_out goes low immediately.
- Frame on the wire:
  - start symbol: always low-half then high-half, regardless of CONVENTION;
  - then DATA_W data symbols, MSB first, each of OVS clocks, OVS/2 clocks per half;
  - then an idle gap of OVS clocks driven low.
- TX states: IDLE → SEND → GAP → IDLE.
  - A word is accepted when tx_valid && tx_ready in cycle N.
  - tx_ready falls in cycle N+1; the first start half begins on tx_out in cycle N+1.
  - tx_ready rises again the cycle after the gap ends.
  - tx_valid/tx_data are ignored while tx_ready=0.
  - tx_data is captured at acceptance; later changes have no effect.
- RX input path: rx_in passes through a 2-FF synchroniser; all timings below are relative to the synchronised signal.
- RX states: UNARMED → ARMED → DATA → DONE → UNARMED.
  - UNARMED: count consecutive low samples; reaching OVS → ARMED. Any high sample resets the count.
  - ARMED: a rising edge marks mid-start-symbol and is time t0 → DATA, rx_busy=1.
  - DATA: bit k (0-based) samples its first half at t0 + OVS/2 + k·OVS + OVS/4 and its second half at t0 + OVS/2 + k·OVS + 3·OVS/4.
  - Equal halves set a sticky frame error.
  - Decoded bit = second-half value (CONVENTION 0) or first-half value (CONVENTION 1).
  - No mid-bit resynchronisation.
  - DONE: one cycle after the last second-half sample, rx_data updates and rx_valid=1 for one cycle; rx_err carries the sticky flag; rx_busy=0; return to UNARMED.
- No receive backpressure: a new frame overwrites rx_data.
- A rising edge seen while UNARMED is ignored; it does not start a frame.

Optional Feature:
MANCH_PARITY_EN
- Defined:
  - TX appends one even-parity symbol over tx_data after the data bits; frame becomes (DATA_W+2)·OVS clocks before the gap.
  - RX decodes that symbol; a parity mismatch ORs into rx_err.
- Undefined: no parity symbol; frame is (DATA_W+1)·OVS clocks.

Decomposition:
- manchester_pkg holds:
  - tx_state_t and rx_state_t enums;
  - CONV_IEEE=0 and CONV_THOMAS=1 constants;
  - a function returning the encoded half-pair for a bit and a convention.
- One sub-module, manchester_sync2: 2-FF synchroniser for rx_in, reset value 0.

Test Plan:
All scenarios use DATA_W=8, OVS=16 and tx_out looped back to rx_in, unless stated.
- CONVENTION=0, send 0xA5 accepted in cycle 0:
  - tx_out active cycles 1..144, low 145..160; tx_ready=1 in cycle 161;
  - rx_valid one pulse, rx_data=0xA5, rx_err=0.
- CONVENTION=1, send 0x3C:
  - start symbol is low→high; every data symbol is inverted relative to the CONVENTION=0 waveform;
  - rx_data=0x3C, rx_err=0.
- tx_valid held high with 0x01 then 0x80:
  - second accept occurs in cycle 161;
  - two rx_valid pulses, rx_data 0x01 then 0x80, both rx_err=0.
- Bench drives rx_in directly with bit 3 both halves high:
  - rx_valid pulses with rx_err=1; the other bits still decode.
- rx_in held low 5 cycles then rising edge:
  - no frame starts, rx_busy=0;
  - after 16 low cycles a valid frame decodes normally.
- Reset at cycle 50 of a frame:
  - tx_out=0 asynchronously, no rx_valid;
  - tx_ready=1 and rx_busy=0 after release.
- Under MANCH_PARITY_EN, send 0x07:
  - frame is 160 active cycles, rx_err=0;
  - with the parity symbol inverted by the bench, rx_err=1.
